// File: rtl/simplerisc_pkg.sv
// Shared constants for the SimpleRisc operand-fetch stage: opcodes and
// control-bus bit positions.
package simplerisc_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int CTRL_W   = 24;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  localparam int CB_ST   = 0;
  localparam int CB_LD   = 1;
  localparam int CB_BEQ  = 2;
  localparam int CB_BGT  = 3;
  localparam int CB_RET  = 4;
  localparam int CB_IMM  = 5;
  localparam int CB_WB   = 6;
  localparam int CB_UBR  = 7;
  localparam int CB_CALL = 8;
  localparam int CB_ADD  = 9;
  localparam int CB_SUB  = 10;
  localparam int CB_CMP  = 11;
  localparam int CB_MUL  = 12;
  localparam int CB_DIV  = 13;
  localparam int CB_MOD  = 14;
  localparam int CB_LSL  = 15;
  localparam int CB_LSR  = 16;
  localparam int CB_ASR  = 17;
  localparam int CB_OR   = 18;
  localparam int CB_AND  = 19;
  localparam int CB_NOT  = 20;
  localparam int CB_MOV  = 21;
  localparam int CB_NOP  = 22;

endpackage

// File: rtl/register_file.sv
// 16x32 register file: two combinational read ports, one write port, with
// write-to-read bypass so OF sees the value WB is writing this cycle.
module register_file
  import simplerisc_pkg::*;
(
  input  logic              clk,
  input  logic              i_reset,
  input  logic [3:0]        i_ra1,
  input  logic [3:0]        i_ra2,
  input  logic [3:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd,
  input  logic              i_we,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_we && (i_wa == i_ra1)) ? i_wd : r_regs[i_ra1];
  assign o_rd2 = (i_we && (i_wa == i_ra2)) ? i_wd : r_regs[i_ra2];

endmodule

// File: rtl/operand_fetch_unit.sv
// SimpleRisc operand-fetch stage: decode, register read, immediate and branch
// target formation, all captured in the OF/EX latch one cycle later.
module operand_fetch_unit
  import simplerisc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              is_wb,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] instruction_out,
  output logic [CTRL_W-1:0] control_bus_out,
  output logic [DATA_W-1:0] btarget,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] op2_out
);

  logic [4:0]        w_opcode;
  logic [3:0]        w_rd, w_rs1, w_rs2, w_ra1, w_ra2;
  logic [1:0]        w_mod;
  logic [15:0]       w_imm16;
  logic [26:0]       w_off27;
  logic [CTRL_W-1:0] w_ctrl;
  logic [DATA_W-1:0] w_rd1, w_rd2, w_immx, w_op2, w_btarget;

  logic [DATA_W-1:0] r_pc_p1, r_ins_p1, r_bt_p1, r_a_p1, r_b_p1, r_op2_p1;
  logic [CTRL_W-1:0] r_ctrl_p1;

  function automatic logic [DATA_W-1:0] imm_extend(input logic [1:0] m,
                                                   input logic [15:0] imm);
    case (m)
      2'b01:   return {16'h0000, imm};
      2'b10:   return {imm, 16'h0000};
      default: return {{16{imm[15]}}, imm};
    endcase
  endfunction

  assign w_opcode = instruction_in[31:27];
  assign w_rd     = instruction_in[25:22];
  assign w_rs1    = instruction_in[21:18];
  assign w_rs2    = instruction_in[17:14];
  assign w_mod    = instruction_in[17:16];
  assign w_imm16  = instruction_in[15:0];
  assign w_off27  = instruction_in[26:0];

  always_comb begin
    w_ctrl         = '0;
    w_ctrl[CB_IMM] = instruction_in[26];
    case (w_opcode)
      OP_ADD:  begin w_ctrl[CB_ADD] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_SUB:  begin w_ctrl[CB_SUB] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_MUL:  begin w_ctrl[CB_MUL] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_DIV:  begin w_ctrl[CB_DIV] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_MOD:  begin w_ctrl[CB_MOD] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_CMP:  w_ctrl[CB_CMP] = 1'b1;
      OP_AND:  begin w_ctrl[CB_AND] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_OR:   begin w_ctrl[CB_OR]  = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_NOT:  begin w_ctrl[CB_NOT] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_MOV:  begin w_ctrl[CB_MOV] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_LSL:  begin w_ctrl[CB_LSL] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_LSR:  begin w_ctrl[CB_LSR] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_ASR:  begin w_ctrl[CB_ASR] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_LD:   begin w_ctrl[CB_LD] = 1'b1; w_ctrl[CB_ADD] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_ST:   begin w_ctrl[CB_ST] = 1'b1; w_ctrl[CB_ADD] = 1'b1; end
      OP_BEQ:  w_ctrl[CB_BEQ] = 1'b1;
      OP_BGT:  w_ctrl[CB_BGT] = 1'b1;
      OP_B:    w_ctrl[CB_UBR] = 1'b1;
      // call only flags the write here; R15 is chosen as destination downstream
      OP_CALL: begin w_ctrl[CB_UBR] = 1'b1; w_ctrl[CB_CALL] = 1'b1; w_ctrl[CB_WB] = 1'b1; end
      OP_RET:  begin w_ctrl[CB_UBR] = 1'b1; w_ctrl[CB_RET] = 1'b1; end
      default: w_ctrl[CB_NOP] = 1'b1;
    endcase
  end

  // ret reads the return address from R15; st reads its data register from rd
  assign w_ra1 = w_ctrl[CB_RET] ? 4'd15 : w_rs1;
  assign w_ra2 = w_ctrl[CB_ST]  ? w_rd  : w_rs2;

  register_file u_regfile (
    .clk     (clk),
    .i_reset (reset),
    .i_ra1   (w_ra1),
    .i_ra2   (w_ra2),
    .i_wa    (wr_adr),
    .i_wd    (wr_data),
    .i_we    (is_wb),
    .o_rd1   (w_rd1),
    .o_rd2   (w_rd2)
  );

  assign w_immx    = imm_extend(w_mod, w_imm16);
  assign w_op2     = w_ctrl[CB_IMM] ? w_immx : w_rd2;
  assign w_btarget = pc_in + {{3{w_off27[26]}}, w_off27, 2'b00};

  // OF/EX latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_p1   <= '0;
      r_ins_p1  <= '0;
      r_ctrl_p1 <= '0;
      r_bt_p1   <= '0;
      r_a_p1    <= '0;
      r_b_p1    <= '0;
      r_op2_p1  <= '0;
    end else begin
      r_pc_p1   <= pc_in;
      r_ins_p1  <= instruction_in;
      r_ctrl_p1 <= w_ctrl;
      r_bt_p1   <= w_btarget;
      r_a_p1    <= w_rd1;
      r_b_p1    <= w_rd2;
      r_op2_p1  <= w_op2;
    end
  end

  assign pc_out          = r_pc_p1;
  assign instruction_out = r_ins_p1;
  assign control_bus_out = r_ctrl_p1;
  assign btarget         = r_bt_p1;
  assign A               = r_a_p1;
  assign B               = r_b_p1;
  assign op2_out         = r_op2_p1;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: directed vector table, bypass/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_operand_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_in, pc_in, wr_data;
  logic [3:0]  wr_adr;
  logic        is_wb;
  logic [31:0] pc_out, instruction_out, btarget, A, B, op2_out;
  logic [23:0] control_bus_out;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] m_regs [16];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] op2;
    logic [23:0] ctrl;
    logic [31:0] bt;
    bit          chk_bt;
  } vec_t;

  vec_t vecs [14];

  operand_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .instruction_in  (instruction_in),
    .pc_in           (pc_in),
    .wr_adr          (wr_adr),
    .wr_data         (wr_data),
    .is_wb           (is_wb),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .control_bus_out (control_bus_out),
    .btarget         (btarget),
    .A               (A),
    .B               (B),
    .op2_out         (op2_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: control word from opcode membership sets
  function automatic logic [23:0] m_ctrl(input logic [31:0] ins);
    int op;
    logic [23:0] c;
    op = int'(ins[31:27]);
    c = '0;
    c[0]  = (op == 15);
    c[1]  = (op == 14);
    c[2]  = (op == 16);
    c[3]  = (op == 17);
    c[4]  = (op == 20);
    c[5]  = ins[26];
    c[6]  = op inside {0, 1, 2, 3, 4, 6, 7, 8, 9, 10, 11, 12, 14, 19};
    c[7]  = op inside {18, 19, 20};
    c[8]  = (op == 19);
    c[9]  = op inside {0, 14, 15};
    c[10] = (op == 1);
    c[11] = (op == 5);
    c[12] = (op == 2);
    c[13] = (op == 3);
    c[14] = (op == 4);
    c[15] = (op == 10);
    c[16] = (op == 11);
    c[17] = (op == 12);
    c[18] = (op == 7);
    c[19] = (op == 6);
    c[20] = (op == 8);
    c[21] = (op == 9);
    c[22] = (op == 13) || (op > 20);
    return c;
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    longint v;
    v = longint'(ins[15:0]);
    case (ins[17:16])
      2'd1:    return 32'(v);
      2'd2:    return 32'(v * 65536);
      default: return (v >= 32768) ? 32'(v - 65536) : 32'(v);
    endcase
  endfunction

  function automatic logic [31:0] m_bt(input logic [31:0] ins, input logic [31:0] pc);
    longint off;
    off = longint'(ins[26:0]);
    if (off >= 64'sd67108864) off = off - 64'sd134217728;
    return 32'(longint'(pc) + 4 * off);
  endfunction

  function automatic logic [31:0] m_read(input int adr);
    if (is_wb && int'(wr_adr) == adr) return wr_data;
    return m_regs[adr];
  endfunction

  task automatic check_outputs(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                               input logic [23:0] ctrl, input logic [31:0] bt, input bit chk_bt,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] op2);
    check({tag, ".pc_out"}, pc_out, pc);
    check({tag, ".instr_out"}, instruction_out, ins);
    check({tag, ".ctrl"}, {8'h0, control_bus_out}, {8'h0, ctrl});
    if (chk_bt) check({tag, ".btarget"}, btarget, bt);
    check({tag, ".A"}, A, a);
    check({tag, ".B"}, B, b);
    check({tag, ".op2"}, op2_out, op2);
  endtask

  initial begin
    vecs[0]  = '{{5'd0, 1'b0, 4'd2, 4'd0, 4'd3, 14'd0}, 32'h10, 32'h0, 32'h3, 32'h3, 24'h000240, 32'h0, 1'b0};
    vecs[1]  = '{{6'b101000, 4'd0, 4'd1, 4'd3, 14'h2000}, 32'h20, 32'hF, 32'h3, 32'h3, 24'h000090, 32'h0, 1'b0};
    vecs[2]  = '{{5'd9, 1'b1, 4'd1, 4'd0, 2'b00, 16'hFFFC}, 32'h0, 32'h0, 32'h3, 32'hFFFFFFFC, 24'h200060, 32'h0, 1'b0};
    vecs[3]  = '{{5'd9, 1'b1, 4'd1, 4'd0, 2'b01, 16'hFFFC}, 32'h0, 32'h0, 32'h7, 32'h0000FFFC, 24'h200060, 32'h0, 1'b0};
    vecs[4]  = '{{5'd9, 1'b1, 4'd1, 4'd0, 2'b10, 16'hFFFC}, 32'h0, 32'h0, 32'hB, 32'hFFFC0000, 24'h200060, 32'h0, 1'b0};
    vecs[5]  = '{{5'd18, 27'd3}, 32'h20, 32'h0, 32'h0, 32'h0, 24'h000080, 32'h2C, 1'b1};
    vecs[6]  = '{{5'd18, 27'h7FFFFFF}, 32'h20, 32'hF, 32'hF, 32'hFFFFFFFF, 24'h0000A0, 32'h1C, 1'b1};
    vecs[7]  = '{{5'd15, 1'b1, 4'd2, 4'd1, 2'b00, 16'd4}, 32'h0, 32'h1, 32'h2, 32'h4, 24'h000221, 32'h0, 1'b0};
    vecs[8]  = '{{5'd5, 27'd0}, 32'h100, 32'h0, 32'h0, 32'h0, 24'h000800, 32'h100, 1'b1};
    vecs[9]  = '{{5'd19, 27'd0}, 32'h100, 32'h0, 32'h0, 32'h0, 24'h0001C0, 32'h100, 1'b1};
    vecs[10] = '{{5'd14, 27'd0}, 32'h100, 32'h0, 32'h0, 32'h0, 24'h000242, 32'h100, 1'b1};
    vecs[11] = '{{5'd25, 27'd0}, 32'h100, 32'h0, 32'h0, 32'h0, 24'h400000, 32'h100, 1'b1};
    vecs[12] = '{{5'd8, 27'd0}, 32'h100, 32'h0, 32'h0, 32'h0, 24'h100040, 32'h100, 1'b1};
    vecs[13] = '{{5'd12, 27'd0}, 32'h100, 32'h0, 32'h0, 32'h0, 24'h020040, 32'h100, 1'b1};

    reset = 1'b1;
    instruction_in = 32'hFFFF_FFFF;
    pc_in = 32'h1234_5678;
    wr_adr = 4'd0;
    wr_data = 32'h0;
    is_wb = 1'b0;
    step();
    check_outputs("reset", 32'h0, 32'h0, 24'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);

    // registers read back as zero straight after reset
    reset = 1'b0;
    instruction_in = {5'd0, 1'b0, 4'd1, 4'd5, 4'd7, 14'd0};
    pc_in = 32'h0;
    step();
    check("rst_regs.A", A, 32'h0);
    check("rst_regs.B", B, 32'h0);

    for (int i = 0; i < 16; i++) begin
      instruction_in = {5'd13, 27'd0};
      is_wb = 1'b1;
      wr_adr = 4'(i);
      wr_data = 32'(i);
      step();
      m_regs[i] = 32'(i);
    end
    is_wb = 1'b0;

    for (int v = 0; v < 14; v++) begin
      instruction_in = vecs[v].instr;
      pc_in = vecs[v].pc;
      step();
      check_outputs($sformatf("vec%0d", v), vecs[v].pc, vecs[v].instr, vecs[v].ctrl,
                    vecs[v].bt, vecs[v].chk_bt, vecs[v].a, vecs[v].b, vecs[v].op2);
    end

    // same-cycle write to the A read address is forwarded
    instruction_in = {5'd15, 1'b1, 4'd2, 4'd1, 2'b00, 16'd4};
    is_wb = 1'b1; wr_adr = 4'd1; wr_data = 32'hDEADBEEF;
    step();
    m_regs[1] = 32'hDEADBEEF;
    check("byp_a.A", A, 32'hDEADBEEF);
    check("byp_a.B", B, 32'h2);

    // same-cycle write to the B read address is forwarded into B and op2
    instruction_in = {5'd0, 1'b0, 4'd2, 4'd1, 4'd5, 14'd0};
    wr_adr = 4'd5; wr_data = 32'h12345678;
    step();
    m_regs[5] = 32'h12345678;
    check("byp_b.A", A, 32'hDEADBEEF);
    check("byp_b.B", B, 32'h12345678);
    check("byp_b.op2", op2_out, 32'h12345678);

    // reset wins over a concurrent write and clears the file
    reset = 1'b1; wr_adr = 4'd7; wr_data = 32'h0000AAAA;
    step();
    check_outputs("rst_wb", 32'h0, 32'h0, 24'h0, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    reset = 1'b0; is_wb = 1'b0;
    instruction_in = {5'd0, 1'b0, 4'd1, 4'd7, 4'd5, 14'd0};
    step();
    check("rst_wb.R7", A, 32'h0);
    check("rst_wb.R5", B, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] e_pc, e_ins, e_bt, e_a, e_b, e_op2;
      logic [23:0] e_ctrl;
      int op, ra1, ra2;
      instruction_in = $urandom;
      pc_in = $urandom;
      reset = ($urandom_range(0, 31) == 0);
      is_wb = 1'($urandom_range(0, 1));
      wr_adr = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      op  = int'(instruction_in[31:27]);
      ra1 = (op == 20) ? 15 : int'(instruction_in[21:18]);
      ra2 = (op == 15) ? int'(instruction_in[25:22]) : int'(instruction_in[17:14]);
      if (reset) begin
        e_pc = 0; e_ins = 0; e_ctrl = 0; e_bt = 0; e_a = 0; e_b = 0; e_op2 = 0;
      end else begin
        e_pc = pc_in;
        e_ins = instruction_in;
        e_ctrl = m_ctrl(instruction_in);
        e_bt = m_bt(instruction_in, pc_in);
        e_a = m_read(ra1);
        e_b = m_read(ra2);
        e_op2 = instruction_in[26] ? m_imm(instruction_in) : e_b;
      end
      step();
      check_outputs($sformatf("rnd%0d", n), e_pc, e_ins, e_ctrl, e_bt, 1'b1, e_a, e_b, e_op2);
      if (reset) begin
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
      end else if (is_wb) begin
        m_regs[wr_adr] = wr_data;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
